// File: rtl/uart_fifo_pkg.sv
// Shared constants, serializer state encoding and sizing helpers for the
// UART word-FIFO blocks (rx gather and tx serializer).
package uart_fifo_pkg;

  localparam int BYTE_W         = 8;
  localparam int DEF_WORD_WIDTH = 256;
  localparam int BYTES_PER_WORD = DEF_WORD_WIDTH / BYTE_W;
  localparam int BIDX_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } ser_state_e;

  // Byte-index width for an arbitrary word width; never narrower than 1 bit.
  function automatic int bidx_width(input int word_width);
    int n;
    n = word_width / BYTE_W;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Register-based synchronous word FIFO with registered level/full/empty.
// Writes while full and reads while empty are ignored.
module sync_word_fifo #(
  parameter int WIDTH       = 256,
  parameter int DEPTH_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH_WIDTH:0]   level
);

  localparam int                   DEPTH   = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] DEPTH_L = (DEPTH_WIDTH + 1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0] LVL_ONE = (DEPTH_WIDTH + 1)'(1);
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE = DEPTH_WIDTH'(1);

  logic [WIDTH-1:0]       mem_r [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr_r;
  logic [DEPTH_WIDTH-1:0] rd_ptr_r;
  logic [DEPTH_WIDTH:0]   level_r;
  logic                   full_r;
  logic                   empty_r;
  logic                   push_s;
  logic                   pop_s;
  logic [DEPTH_WIDTH:0]   level_nxt_s;

  // Qualify requests against the registered flags and compute the next level.
  always_comb begin
    push_s      = wr_en && !full_r;
    pop_s       = rd_en && !empty_r;
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // Pointers, level and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {DEPTH_WIDTH{1'b0}};
      rd_ptr_r <= {DEPTH_WIDTH{1'b0}};
      level_r  <= {(DEPTH_WIDTH + 1){1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r <= level_nxt_s;
      full_r  <= (level_nxt_s == DEPTH_L);
      empty_r <= (level_nxt_s == {(DEPTH_WIDTH + 1){1'b0}});
    end
  end

  // Storage array; cleared on reset so discarded words never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign full    = full_r;
  assign empty   = empty_r;
  assign level   = level_r;

endmodule

// File: rtl/uart_tx_word_serializer.sv
// Buffers wide datapath words and streams them byte by byte to uart_tx over
// a valid/ready interface, chaining words back-to-back without bubbles.
module uart_tx_word_serializer
  import uart_fifo_pkg::*;
#(
  parameter int WORD_WIDTH  = 256,
  parameter int DEPTH_WIDTH = 2,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WORD_WIDTH-1:0]  wr_data,
  output logic                   wr_full,
  output logic                   wr_overflow,
  output logic [DEPTH_WIDTH:0]   word_level,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy
);

  localparam int            BPW      = WORD_WIDTH / BYTE_W;
  localparam int            BW       = bidx_width(WORD_WIDTH);
  localparam logic [BW-1:0] LAST_IDX = BW'(BPW - 1);
  localparam logic [BW-1:0] IDX_ONE  = BW'(1);
  localparam logic [BW-1:0] IDX_ZERO = BW'(0);

  logic [WORD_WIDTH-1:0]  fifo_rd_data_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [DEPTH_WIDTH:0]   fifo_level_s;
  logic                   pop_s;
  logic                   beat_s;
  logic                   last_s;

  ser_state_e             state_r;
  ser_state_e             state_nxt_s;
  logic [BW-1:0]          byte_idx_r;
  logic [BW-1:0]          byte_idx_nxt_s;
  logic [WORD_WIDTH-1:0]  shift_r;
  logic [WORD_WIDTH-1:0]  shift_nxt_s;
  logic [7:0]             tx_data_r;
  logic [7:0]             tx_data_nxt_s;
  logic                   tx_valid_r;
  logic                   tx_valid_nxt_s;
  logic                   overflow_r;

  // Byte lane for a given send position, honouring the transmit order.
  function automatic logic [7:0] pick_byte(input logic [WORD_WIDTH-1:0] w,
                                           input logic [BW-1:0]         idx);
    int k;
    k = MSB_FIRST ? (BPW - 1 - int'(idx)) : int'(idx);
    return w[k*BYTE_W +: BYTE_W];
  endfunction

  sync_word_fifo #(
    .WIDTH       (WORD_WIDTH),
    .DEPTH_WIDTH (DEPTH_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop_s),
    .rd_data (fifo_rd_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (fifo_level_s)
  );

  // Serializer FSM: load on idle, advance on beats, chain or retire after the last byte.
  always_comb begin
    beat_s         = tx_valid_r && tx_ready;
    last_s         = (byte_idx_r == LAST_IDX);
    pop_s          = 1'b0;
    state_nxt_s    = state_r;
    byte_idx_nxt_s = byte_idx_r;
    shift_nxt_s    = shift_r;
    tx_data_nxt_s  = tx_data_r;
    tx_valid_nxt_s = tx_valid_r;
    case (state_r)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s          = 1'b1;
          state_nxt_s    = S_SEND;
          byte_idx_nxt_s = IDX_ZERO;
          shift_nxt_s    = fifo_rd_data_s;
          tx_data_nxt_s  = pick_byte(fifo_rd_data_s, IDX_ZERO);
          tx_valid_nxt_s = 1'b1;
        end else begin
          tx_data_nxt_s  = 8'h00;
          tx_valid_nxt_s = 1'b0;
        end
      end
      S_SEND: begin
        if (!beat_s) begin
          tx_valid_nxt_s = 1'b1;
        end else if (!last_s) begin
          byte_idx_nxt_s = byte_idx_r + IDX_ONE;
          tx_data_nxt_s  = pick_byte(shift_r, byte_idx_r + IDX_ONE);
        end else if (!fifo_empty_s) begin
          // Chain straight into the next queued word on the same edge.
          pop_s          = 1'b1;
          byte_idx_nxt_s = IDX_ZERO;
          shift_nxt_s    = fifo_rd_data_s;
          tx_data_nxt_s  = pick_byte(fifo_rd_data_s, IDX_ZERO);
        end else begin
          state_nxt_s    = S_IDLE;
          tx_data_nxt_s  = 8'h00;
          tx_valid_nxt_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s    = S_IDLE;
        byte_idx_nxt_s = IDX_ZERO;
        tx_data_nxt_s  = 8'h00;
        tx_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Serializer state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      byte_idx_r <= IDX_ZERO;
      shift_r    <= {WORD_WIDTH{1'b0}};
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      byte_idx_r <= byte_idx_nxt_s;
      shift_r    <= shift_nxt_s;
      tx_data_r  <= tx_data_nxt_s;
      tx_valid_r <= tx_valid_nxt_s;
    end
  end

  // Sticky overflow: any write attempt against a full FIFO, even if a pop coincides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (wr_en && fifo_full_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign wr_full     = fifo_full_s;
  assign wr_overflow = overflow_r;
  assign word_level  = fifo_level_s;
  assign tx_data     = tx_data_r;
  assign tx_valid    = tx_valid_r;
  assign busy        = tx_valid_r || (fifo_level_s != {(DEPTH_WIDTH + 1){1'b0}});

endmodule

// File: tb/tb_uart_tx_word_serializer.sv
// Scoreboard bench: LSB-first and MSB-first instances share stimulus; a
// transaction-level model predicts acceptance, occupancy and byte order.
module tb_uart_tx_word_serializer;

  localparam int WW    = 256;
  localparam int DW    = 2;
  localparam int BPW   = WW / 8;
  localparam int DEPTH = 1 << DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [WW-1:0] wr_data = '0;
  logic          tx_ready = 1'b0;

  logic          wr_full_l, wr_overflow_l, tx_valid_l, busy_l;
  logic [DW:0]   word_level_l;
  logic [7:0]    tx_data_l;
  logic          wr_full_m, wr_overflow_m, tx_valid_m, busy_m;
  logic [DW:0]   word_level_m;
  logic [7:0]    tx_data_m;

  always #5 clk = ~clk;

  uart_tx_word_serializer #(.WORD_WIDTH(WW), .DEPTH_WIDTH(DW), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(wr_full_l), .wr_overflow(wr_overflow_l), .word_level(word_level_l),
    .tx_data(tx_data_l), .tx_valid(tx_valid_l), .tx_ready(tx_ready), .busy(busy_l));

  uart_tx_word_serializer #(.WORD_WIDTH(WW), .DEPTH_WIDTH(DW), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(wr_full_m), .wr_overflow(wr_overflow_m), .word_level(word_level_m),
    .tx_data(tx_data_m), .tx_valid(tx_valid_m), .tx_ready(tx_ready), .busy(busy_m));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: expected byte streams plus abstract occupancy.
  logic [7:0] exp_l[$];
  logic [7:0] exp_m[$];
  int         m_fifo = 0;
  int         m_rem  = 0;
  bit         m_act  = 1'b0;
  bit         m_ovf  = 1'b0;
  bit         stall_l = 1'b0, stall_m = 1'b0;
  logic [7:0] hold_l, hold_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare outputs to the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_l.delete(); exp_m.delete();
      m_fifo = 0; m_rem = 0; m_act = 1'b0; m_ovf = 1'b0;
      stall_l = 1'b0; stall_m = 1'b0;
      chk("rst_tx_valid", tx_valid_l, 0);
      chk("rst_tx_valid_msb", tx_valid_m, 0);
      chk("rst_wr_full", wr_full_l, 0);
      chk("rst_word_level", word_level_l, 0);
      chk("rst_busy", busy_l, 0);
      chk("rst_wr_overflow", wr_overflow_l, 0);
      chk("rst_tx_data", tx_data_l, 0);
    end else begin
      bit beat, pop, acc;
      chk("tx_valid", tx_valid_l, m_act);
      chk("tx_valid_msb", tx_valid_m, m_act);
      chk("word_level", word_level_l, m_fifo);
      chk("word_level_msb", word_level_m, m_fifo);
      chk("wr_full", wr_full_l, (m_fifo == DEPTH));
      chk("wr_overflow", wr_overflow_l, m_ovf);
      chk("wr_overflow_msb", wr_overflow_m, m_ovf);
      chk("busy", busy_l, (m_act || m_fifo != 0));
      chk("busy_msb", busy_m, (m_act || m_fifo != 0));
      if (stall_l) chk("stall_hold", tx_data_l, hold_l);
      if (stall_m) chk("stall_hold_msb", tx_data_m, hold_m);
      if (tx_valid_l && tx_ready) begin
        if (exp_l.size() == 0) chk("unexpected_byte", tx_data_l, 32'hFFFF_FFFF);
        else chk("byte_lsb", tx_data_l, exp_l.pop_front());
      end
      if (tx_valid_m && tx_ready) begin
        if (exp_m.size() == 0) chk("unexpected_byte_msb", tx_data_m, 32'hFFFF_FFFF);
        else chk("byte_msb", tx_data_m, exp_m.pop_front());
      end
      stall_l = tx_valid_l && !tx_ready; hold_l = tx_data_l;
      stall_m = tx_valid_m && !tx_ready; hold_m = tx_data_m;

      beat = m_act && tx_ready;
      pop  = (m_fifo != 0) && (!m_act || (beat && m_rem == 1));
      acc  = wr_en && (m_fifo < DEPTH);
      if (wr_en && !acc) m_ovf = 1'b1;
      if (acc) begin
        for (int k = 0; k < BPW; k++) begin
          exp_l.push_back(wr_data[8*k +: 8]);
          exp_m.push_back(wr_data[8*(BPW-1-k) +: 8]);
        end
      end
      if (beat) begin
        m_rem--;
        if (m_rem == 0) m_act = 1'b0;
      end
      if (pop) begin
        m_fifo--; m_act = 1'b1; m_rem = BPW;
      end
      if (acc) m_fifo++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WW-1:0] rand_word();
    logic [WW-1:0] w;
    for (int k = 0; k < WW / 32; k++) w[32*k +: 32] = $urandom();
    return w;
  endfunction

  task automatic wait_idle(input string tag, input bit rnd_ready);
    int cyc = 0;
    while ((m_act || m_fifo != 0) && cyc < 4000) begin
      if (rnd_ready) tx_ready = $urandom_range(0, 1);
      tick();
      cyc++;
    end
    chk({tag, "_drain_timeout"}, (m_act || m_fifo != 0), 0);
    chk({tag, "_bytes_left"}, exp_l.size(), 0);
    chk({tag, "_bytes_left_msb"}, exp_m.size(), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WW-1:0] w;
    int gaps;

    // Reset with random inputs
    rst_n = 1'b0;
    repeat (4) begin
      wr_en = $urandom_range(0, 1); wr_data = rand_word(); tx_ready = $urandom_range(0, 1);
      tick();
    end
    wr_en = 1'b0; tx_ready = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single word with byte i = i, latency check
    for (int k = 0; k < BPW; k++) w[8*k +: 8] = 8'(k);
    tx_ready = 1'b1;
    wr_data = w; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("latency_t0", tx_valid_l, 0);
    tick();
    chk("latency_t1", tx_valid_l, 1);
    chk("first_byte_lsb", tx_data_l, 8'h00);
    chk("first_byte_msb", tx_data_m, 8'h1F);
    wait_idle("single", 1'b0);

    // Backpressure
    wr_data = rand_word(); wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    wait_idle("backpressure", 1'b1);

    // Fill and overflow
    tx_ready = 1'b0;
    for (int n = 0; n < 6; n++) begin
      wr_data = rand_word(); wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    chk("fill_full", wr_full_l, 1);
    chk("fill_level", word_level_l, 4);
    chk("fill_overflow", wr_overflow_l, 1);
    chk("fill_queued", exp_l.size(), 5 * BPW);
    tx_ready = 1'b1;
    wait_idle("fill", 1'b0);

    // Chaining: two words, contiguous valid
    tx_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      wr_data = rand_word(); wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    tick();
    tx_ready = 1'b1;
    gaps = 0;
    for (int i = 0; i < 2 * BPW; i++) begin
      if (!tx_valid_l) gaps++;
      tick();
    end
    chk("chain_gaps", gaps, 0);
    chk("chain_end_valid", tx_valid_l, 0);
    wait_idle("chain", 1'b0);

    // Reset mid-word with a second word queued
    tx_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      wr_data = rand_word(); wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    tick();
    tx_ready = 1'b1;
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", tx_valid_l, 0);
    chk("async_rst_valid_msb", tx_valid_m, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) tick();
    chk("post_rst_level", word_level_l, 0);
    chk("post_rst_busy", busy_l, 0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      wr_en = ($urandom_range(0, 99) < 35);
      wr_data = rand_word();
      tx_ready = $urandom_range(0, 1);
      tick();
    end
    wr_en = 1'b0;
    tx_ready = 1'b1;
    wait_idle("random", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_word_serializer.md
Name: uart_tx_word_serializer

Overview:
Transmit-direction counterpart of the UART receive byte-to-word gather FIFO. It accepts wide words (256-bit results or feature data) from the accelerator datapath and buffers them in a small word FIFO. It then serializes each word into bytes on a valid/ready stream that feeds the UART transmitter. It sits between the compute core write-back and uart_tx.

Parameters:
WORD_WIDTH, 256, input word width in bits; must be a multiple of 8.
DEPTH_WIDTH, 2, log2 of word FIFO depth (default depth 4 words).
MSB_FIRST, 0, 0 sends byte [7:0] first; 1 sends byte [WORD_WIDTH-1:WORD_WIDTH-8] first.

Ports:
clk  in  1  single system clock.
rst_n  in  1  asynchronous active-low reset.
wr_en  in  1  write strobe; word is accepted when wr_en && !wr_full.
wr_data  in  WORD_WIDTH  word to send.
wr_full  out  1  word FIFO full.
wr_overflow  out  1  sticky flag; set on wr_en while wr_full; cleared only by reset.
word_level  out  DEPTH_WIDTH+1  words held in FIFO (the word currently being serialized is excluded).
tx_data  out  8  current byte.
tx_valid  out  1  tx_data is valid.
tx_ready  in  1  uart_tx accepts the byte; a beat is tx_valid && tx_ready.
busy  out  1  high when tx_valid=1 or word_level!=0.

Behaviour:
- Reset (async assert, sync release): all outputs are 0; FIFO pointers, byte index, and the serializer register are cleared; wr_overflow is cleared.
- FIFO: synchronous, registered count. wr_full = (word_level == 2**DEPTH_WIDTH).
  - A write while full is dropped and sets wr_overflow, even if a pop occurs in the same cycle.
  - A simultaneous push and pop with neither full nor empty leaves word_level unchanged.
- Serializer FSM states:
  - IDLE: tx_valid=0.
  - SEND: tx_valid=1.
- IDLE -> SEND when word_level!=0. That edge pops the head word into the shift register, sets byte_idx=0, and sets tx_valid=1.
- Latency: for a word written at edge t into an empty, idle block, tx_valid is high after edge t+1 (first byte in cycle t+2).
- In SEND, tx_data = byte selected by byte_idx and MSB_FIRST. tx_data and tx_valid hold stable while tx_ready=0.
- On a beat with byte_idx < WORD_WIDTH/8-1: byte_idx increments.
- On a beat with byte_idx == WORD_WIDTH/8-1 (last byte):
  - If word_level!=0, the next word is popped on the same edge and byte_idx=0. There is no bubble and tx_valid stays 1.
  - Otherwise return to IDLE and tx_valid drops on that edge.
- A write to an empty FIFO on the same edge as the last-byte beat does not chain. The FSM goes to IDLE and reloads next cycle (one-cycle bubble is allowed).
- tx_valid never drops without a beat, except on reset.
- Reset mid-word: tx_valid drops immediately (async). Unsent bytes and FIFO contents are discarded.
- byte_idx width is clog2(WORD_WIDTH/8); it wraps only through the explicit reload.

Decomposition:
- Shared package uart_fifo_pkg:
  - BYTE_W=8
  - BYTES_PER_WORD=WORD_WIDTH/8
  - BIDX_W=clog2(BYTES_PER_WORD)
  - FSM state enum {S_IDLE, S_SEND}
- One sub-module, sync_word_fifo: parameterised width/depth register FIFO with wr_en/rd_en/full/empty/level.
- The serializer FSM, byte mux, and overflow flag live in the top.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> tx_valid=0, wr_full=0, word_level=0, busy=0, wr_overflow=0. Then release.
- Single word, bytes i=i (0x1F1E..0100), tx_ready=1, MSB_FIRST=0 -> 32 consecutive beats 0x00..0x1F, first in cycle t+2, tx_valid=0 after byte 0x1F. With MSB_FIRST=1 the order is 0x1F..0x00.
- Backpressure: tx_ready pseudo-random 50% -> tx_data unchanged while tx_valid&&!tx_ready; all 32 bytes delivered in order, none duplicated.
- Fill: tx_ready=0, write 6 words back-to-back:
  - The first word is loaded into the serializer; words 2-5 fill the FIFO, so wr_full=1 and word_level=4.
  - The 6th write is dropped and wr_overflow=1.
  - Then tx_ready=1 -> exactly 160 bytes from words 1-5.
- Chaining: two words queued, tx_ready=1 -> 64 beats with tx_valid continuously high, no bubble between byte 31 and byte 32.
- Reset mid-operation: after 10 beats of word A with word B queued, pulse rst_n low -> tx_valid=0 asynchronously. After release, no further beats, word_level=0, busy=0.
